// File: rtl/tdc_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_measure_ctrl
//   Sequencer for one TDC measurement. After arm it counts clock cycles (the
//   coarse count). On the first rising edge of hit it captures the delay-line
//   taps into the encoder's input register. Once the registered thermometer
//   encoder has settled, it collects the 5-bit fine code. It then presents
//   {coarse, fine} on a valid/ready result port.
//
// Parameters
//   CW             coarse counter width
//   ENC_LATENCY    encoder clk-to-bin latency in cycles (>= 1)
//   TIMEOUT_CYCLES ARMED timeout length; only used when TDC_TIMEOUT_EN is set
//
// Configuration macro
//   TDC_TIMEOUT_EN  when defined, an ARMED measurement with no hit ends after
//                   TIMEOUT_CYCLES cycles with res_timeout=1. When it is
//                   undefined, ARMED waits forever and res_timeout is tied to 0.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   arm          start request (sampled only in IDLE)
//   abort        cancel in ARMED / WAIT_ENC, no result produced
//   hit          synchronous stop signal; a rising edge is the event
//   thermo_in    raw delay-line taps
//   enc_thermo   registered thermometer code driven to the encoder
//   enc_bin      encoder binary output
//   busy         high in any state other than IDLE
//   res_valid    result available, held until res_ready
//   res_ready    consumer accepts the result
//   res_coarse   coarse count at hit
//   res_fine     fine code from the encoder
//   res_ovf      coarse counter saturated before the hit
//   res_timeout  measurement ended by timeout
// -----------------------------------------------------------------------------
module tdc_measure_ctrl #(
  parameter int CW             = 16,
  parameter int ENC_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic          hit,
  input  logic [31:0]   thermo_in,
  output logic [31:0]   enc_thermo,
  input  logic [4:0]    enc_bin,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_coarse,
  output logic [4:0]    res_fine,
  output logic          res_ovf,
  output logic          res_timeout
);

  // Wide enough to hold ENC_LATENCY itself.
  localparam int WW = (ENC_LATENCY < 1) ? 1 : $clog2(ENC_LATENCY + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_PRE  = CNT_MAX - 1'b1;

  if (ENC_LATENCY < 1 || TIMEOUT_CYCLES < 1 ||
      longint'(TIMEOUT_CYCLES) >= (longint'(1) << CW)) begin : g_bad_param
    $error("tdc_measure_ctrl: ENC_LATENCY must be >= 1 and TIMEOUT_CYCLES in [1, 2**CW-1]");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_ENC, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          hit_d;
  logic          hit_edge;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic [WW-1:0] wcnt;
  logic          enc_done;
  logic          timeout_fire;

  assign hit_edge = hit & ~hit_d;
  // The encoder output is sampled ENC_LATENCY+1 edges after the capture edge.
  assign enc_done = (wcnt == WW'(ENC_LATENCY));

`ifdef TDC_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  // A hit edge in the last ARMED cycle takes priority over the timeout.
  assign timeout_fire = (cnt == TO_LAST) && !hit_edge;
`else
  assign timeout_fire = 1'b0;
  assign res_timeout  = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (arm) state_nxt = S_ARMED;
      S_ARMED: begin
        if (abort)             state_nxt = S_IDLE;
        else if (hit_edge)     state_nxt = S_WAIT_ENC;
        else if (timeout_fire) state_nxt = S_DONE;
      end
      S_WAIT_ENC: begin
        if (abort)         state_nxt = S_IDLE;
        else if (enc_done) state_nxt = S_DONE;
      end
      S_DONE:     if (res_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy      = (state != S_IDLE);
    res_valid = (state == S_DONE);
  end

  // Datapath: edge detector, coarse counter, encoder input and result regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_d       <= 1'b0;
      cnt         <= '0;
      ovf         <= 1'b0;
      wcnt        <= '0;
      enc_thermo  <= '0;
      res_coarse  <= '0;
      res_fine    <= '0;
      res_ovf     <= 1'b0;
`ifdef TDC_TIMEOUT_EN
      res_timeout <= 1'b0;
`endif
    end else begin
      hit_d <= hit;
      unique case (state)
        S_IDLE: begin
          if (arm) begin
            cnt <= '0;
            ovf <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!abort) begin
            if (hit_edge) begin
              enc_thermo <= thermo_in;
              res_coarse <= cnt;
              wcnt       <= '0;
            end else if (timeout_fire) begin
`ifdef TDC_TIMEOUT_EN
              res_coarse  <= TO_LAST;
              res_fine    <= '0;
              res_ovf     <= ovf;
              res_timeout <= 1'b1;
`endif
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
              // ovf goes high together with the counter reaching its maximum.
              if (cnt == CNT_PRE) ovf <= 1'b1;
            end
          end
        end
        S_WAIT_ENC: begin
          if (!abort) begin
            if (enc_done) begin
              res_fine    <= enc_bin;
              res_ovf     <= ovf;
`ifdef TDC_TIMEOUT_EN
              res_timeout <= 1'b0;
`endif
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
